// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg: shared op/state encodings for calc_seq.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_MUL  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam int         MUL_ITERS = 6;
  localparam logic [2:0] MUL_LAST  = 3'(MUL_ITERS - 1);

endpackage

`default_nettype wire

// File: rtl/sixbitadd.sv
// ---------------------------------------------------------------------------
// sixbitadd: 6-bit adder with carry-in, carry-out and signed overflow.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sixbitadd (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       cin,
  output logic [5:0] sum,
  output logic       cout,
  output logic       ovf
);

  logic [6:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {6'd0, cin};
  assign sum   = total[5:0];
  assign cout  = total[6];
  // Same-sign operands producing an opposite-sign sum: carry into MSB differs from carry out.
  assign ovf   = (a[5] == b[5]) && (sum[5] != a[5]);

endmodule

`default_nettype wire

// File: rtl/calc_seq.sv
// ---------------------------------------------------------------------------
// calc_seq: sequential ADD/SUB/shift-add MUL unit around one shared adder.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module calc_seq
  import calc_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         err
);

  state_t       state;
  logic [1:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] acc;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic [2:0]   cnt;
  logic         ovf;

  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_sum;
  logic         add_cout;
  logic         add_ovf;

  logic [W-1:0] acc_next;
  logic         ovf_next;

  // The single adder serves EXEC (a +/- b) and each MUL step (acc + mcand).
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == ST_EXEC) begin
      add_a   = a_q;
      add_b   = (op_q == OP_SUB) ? ~b_q : b_q;
      add_cin = (op_q == OP_SUB);
    end else if (state == ST_MUL) begin
      add_a = acc;
      add_b = mcand;
    end
  end

  sixbitadd u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  // A set mcand MSB about to be shifted out still matters if any multiplier bits remain.
  always_comb begin
    acc_next = mplier[0] ? add_sum : acc;
    ovf_next = ovf | (mplier[0] & add_cout) | (mcand[W-1] & (|mplier[W-1:1]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op;
            a_q    <= a;
            b_q    <= b;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
            ovf    <= 1'b0;
            state  <= (op == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_q == OP_RSV) begin
            result   <= '0;
            overflow <= 1'b0;
            err      <= 1'b1;
          end else begin
            result   <= add_sum;
            overflow <= add_ovf;
            err      <= 1'b0;
          end
          state <= ST_DONE;
        end
        ST_MUL: begin
          acc    <= acc_next;
          ovf    <= ovf_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          if (cnt == MUL_LAST) begin
            result   <= acc_next;
            overflow <= ovf_next;
            err      <= 1'b0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_EXEC) || (state == ST_MUL);
  assign done = (state == ST_DONE);

endmodule

`default_nettype wire
